// File: rtl/ascii_to_ps2_tx_pkg.sv
// Shared PS/2 transmit definitions: break code, lookup sentinel, frame size,
// FSM states and the 11-bit frame builder.
package ps2_pkg;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] NO_CODE    = 8'h00;
  localparam int         FRAME_BITS = 11;

  typedef enum logic [1:0] {IDLE, FRAME, GAP} state_t;

  // Frame in transmit order from bit 0: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [FRAME_BITS-1:0] ps2_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

endpackage

// File: rtl/ascii_to_ps2_tx_if.sv
// Character handshake between a character source and the PS/2 transmitter.
interface ascii_to_ps2_tx_if;
  logic [7:0] ascii_in;
  logic       ascii_valid;
  logic       ascii_ready;

  modport master (output ascii_in, output ascii_valid, input  ascii_ready);
  modport slave  (input  ascii_in, input  ascii_valid, output ascii_ready);
endinterface

// File: rtl/ascii_to_ps2_tx_scan.sv
// ASCII -> PS/2 set-2 make code, inverse of the keyboard decode table.
// Returns NO_CODE for characters without a key.
// Option: PS2_TX_CASEFOLD_EN folds 'a'-'z' onto the 'A'-'Z' make codes.
module ascii_to_scan
  import ps2_pkg::*;
(
  input  logic [7:0] ascii_i,
  output logic [7:0] code_o
);

  logic [7:0] ch;

  // Optional case folding, then a flat table lookup.
  always_comb begin
    ch = ascii_i;
`ifdef PS2_TX_CASEFOLD_EN
    if (ascii_i >= 8'h61 && ascii_i <= 8'h7A) ch = ascii_i - 8'h20;
`endif
    code_o = NO_CODE;
    case (ch)
      8'h30: code_o = 8'h45;  8'h31: code_o = 8'h16;  8'h32: code_o = 8'h1E;
      8'h33: code_o = 8'h26;  8'h34: code_o = 8'h25;  8'h35: code_o = 8'h2E;
      8'h36: code_o = 8'h36;  8'h37: code_o = 8'h3D;  8'h38: code_o = 8'h3E;
      8'h39: code_o = 8'h46;
      8'h41: code_o = 8'h1C;  8'h42: code_o = 8'h32;  8'h43: code_o = 8'h21;
      8'h44: code_o = 8'h23;  8'h45: code_o = 8'h24;  8'h46: code_o = 8'h2B;
      8'h47: code_o = 8'h34;  8'h48: code_o = 8'h33;  8'h49: code_o = 8'h43;
      8'h4A: code_o = 8'h3B;  8'h4B: code_o = 8'h42;  8'h4C: code_o = 8'h4B;
      8'h4D: code_o = 8'h3A;  8'h4E: code_o = 8'h31;  8'h4F: code_o = 8'h44;
      8'h50: code_o = 8'h4D;  8'h51: code_o = 8'h15;  8'h52: code_o = 8'h2D;
      8'h53: code_o = 8'h1B;  8'h54: code_o = 8'h2C;  8'h55: code_o = 8'h3C;
      8'h56: code_o = 8'h2A;  8'h57: code_o = 8'h1D;  8'h58: code_o = 8'h22;
      8'h59: code_o = 8'h35;  8'h5A: code_o = 8'h1A;
      8'h60: code_o = 8'h0E;  8'h2D: code_o = 8'h4E;  8'h3D: code_o = 8'h55;
      8'h5B: code_o = 8'h54;  8'h5D: code_o = 8'h5B;  8'h5C: code_o = 8'h5D;
      8'h3B: code_o = 8'h4C;  8'h27: code_o = 8'h52;  8'h2C: code_o = 8'h41;
      8'h2E: code_o = 8'h49;  8'h2F: code_o = 8'h4A;
      8'h20: code_o = 8'h29;  8'h0D: code_o = 8'h5A;  8'h08: code_o = 8'h66;
      default: code_o = NO_CODE;
    endcase
  end

endmodule

// File: rtl/ascii_to_ps2_tx.sv
// PS/2 device-side transmitter: one accepted character becomes the byte
// sequence {make, F0, make}, each byte an 11-bit frame followed by an idle gap.
// Option: PS2_TX_CASEFOLD_EN (handled in ascii_to_scan).
module ascii_to_ps2_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV    = 2500,
  parameter int GAP_CYCLES = 50000
)(
  input  logic               clk,
  input  logic               rst_n,
  ascii_to_ps2_tx_if.slave   host,
  output logic               ps2_clk,
  output logic               ps2_data,
  output logic               busy,
  output logic               unmapped
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int GAP_W = $clog2(GAP_CYCLES) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       BIT_LAST = 4'(FRAME_BITS - 1);

  state_t                 state_q;
  logic [7:0]             code_q;
  logic [1:0]             byte_q;     // 3 after the last frame = sequence done
  logic [3:0]             bit_q;
  logic                   half_q;     // 0: clock-high half, 1: clock-low half
  logic [DIV_W-1:0]       div_q;
  logic [GAP_W-1:0]       gap_q;
  logic                   ps2_clk_q, ps2_data_q, unmapped_q;

  logic [7:0]             lut_code, cur_byte;
  logic [FRAME_BITS-1:0]  frame_w;
  logic [3:0]             nxt_bit;

  ascii_to_scan u_lut (.ascii_i(host.ascii_in), .code_o(lut_code));

  assign cur_byte = (byte_q == 2'd1) ? BREAK_CODE : code_q;
  assign frame_w  = ps2_frame(cur_byte);
  assign nxt_bit  = bit_q + 4'd1;

  assign host.ascii_ready = (state_q == IDLE);
  assign busy             = (state_q != IDLE);
  assign ps2_clk          = ps2_clk_q;
  assign ps2_data         = ps2_data_q;
  assign unmapped         = unmapped_q;

  // Sequencer and bit serializer; line levels are registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      code_q     <= NO_CODE;
      byte_q     <= 2'd0;
      bit_q      <= 4'd0;
      half_q     <= 1'b0;
      div_q      <= '0;
      gap_q      <= '0;
      ps2_clk_q  <= 1'b1;
      ps2_data_q <= 1'b1;
      unmapped_q <= 1'b0;
    end else begin
      unmapped_q <= 1'b0;
      case (state_q)
        IDLE: if (host.ascii_valid) begin
          code_q <= lut_code;
          if (lut_code == NO_CODE) begin
            unmapped_q <= 1'b1;
          end else begin
            state_q    <= FRAME;
            byte_q     <= 2'd0;
            bit_q      <= 4'd0;
            half_q     <= 1'b0;
            div_q      <= '0;
            ps2_clk_q  <= 1'b1;
            ps2_data_q <= 1'b0;            // start bit
          end
        end
        FRAME: if (div_q == DIV_LAST) begin
          div_q <= '0;
          if (!half_q) begin
            half_q    <= 1'b1;
            ps2_clk_q <= 1'b0;             // host samples on this fall
          end else begin
            half_q    <= 1'b0;
            ps2_clk_q <= 1'b1;
            if (bit_q == BIT_LAST) begin
              state_q    <= GAP;
              gap_q      <= '0;
              ps2_data_q <= 1'b1;
              byte_q     <= byte_q + 2'd1;
            end else begin
              bit_q      <= nxt_bit;
              ps2_data_q <= frame_w[nxt_bit];
            end
          end
        end else begin
          div_q <= div_q + DIV_W'(1);
        end
        GAP: if (gap_q == GAP_LAST) begin
          if (byte_q == 2'd3) begin
            state_q <= IDLE;
          end else begin
            state_q    <= FRAME;
            bit_q      <= 4'd0;
            half_q     <= 1'b0;
            div_q      <= '0;
            ps2_data_q <= 1'b0;
          end
        end else begin
          gap_q <= gap_q + GAP_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ascii_to_ps2_tx.sv
// Directed bench for ascii_to_ps2_tx with CLK_DIV=4, GAP_CYCLES=16
// (frame 88 cycles, character 312 cycles). A PS/2 host model decodes
// bytes on every ps2_clk fall.
module tb_ascii_to_ps2_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2_clk, ps2_data, busy, unmapped;
  int   n_tests = 0;
  int   n_fail  = 0;

  ascii_to_ps2_tx_if ifc ();

  ascii_to_ps2_tx #(.CLK_DIV(4), .GAP_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .host(ifc.slave),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data), .busy(busy), .unmapped(unmapped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Host receiver model
  logic [7:0]  rx_q[$];
  logic [10:0] rx_bits;
  int          rx_n = 0;
  logic        prev_clk = 1'b1;

  always @(negedge clk) begin
    if (!rst_n) begin
      rx_n = 0;
    end else if (prev_clk && !ps2_clk) begin
      rx_bits[rx_n] = ps2_data;
      rx_n++;
      if (rx_n == 11) begin
        chk("rx_start",  {31'd0, rx_bits[0]}, 32'd0);
        chk("rx_parity", {31'd0, rx_bits[9]}, {31'd0, ~^rx_bits[8:1]});
        chk("rx_stop",   {31'd0, rx_bits[10]}, 32'd1);
        rx_q.push_back(rx_bits[8:1]);
        rx_n = 0;
      end
    end
    prev_clk = ps2_clk;
  end

  function automatic logic [31:0] rx_pack();
    logic [31:0] v;
    v = '0;
    foreach (rx_q[i]) v = {v[23:0], rx_q[i]};
    return {rx_q.size() > 4 ? 8'hEE : 8'h00, v[23:0]} | (rx_q.size() == 3 ? 32'd0 : 32'h0100_0000);
  endfunction

  // Present c at a negedge; returns at the negedge after the transfer edge.
  task automatic send(input logic [7:0] c);
    ifc.ascii_in = c;
    ifc.ascii_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifc.ascii_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (!ifc.ascii_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("idle_timeout", 32'(n), 32'd0);
  endtask

  logic [7:0] mp_a [50] = '{8'h30,8'h31,8'h32,8'h33,8'h34,8'h35,8'h36,8'h37,8'h38,8'h39,
    8'h41,8'h42,8'h43,8'h44,8'h45,8'h46,8'h47,8'h48,8'h49,8'h4A,8'h4B,8'h4C,8'h4D,
    8'h4E,8'h4F,8'h50,8'h51,8'h52,8'h53,8'h54,8'h55,8'h56,8'h57,8'h58,8'h59,8'h5A,
    8'h60,8'h2D,8'h3D,8'h5B,8'h5D,8'h5C,8'h3B,8'h27,8'h2C,8'h2E,8'h2F,8'h20,8'h0D,8'h08};
  logic [7:0] mp_c [50] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46,
    8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,8'h42,8'h4B,8'h3A,
    8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A,
    8'h0E,8'h4E,8'h55,8'h54,8'h5B,8'h5D,8'h4C,8'h52,8'h41,8'h49,8'h4A,8'h29,8'h5A,8'h66};
  logic [7:0] um_a [5] = '{8'h2A, 8'h40, 8'h7F, 8'h09, 8'h00};

  logic [88:0] clk_s, dat_s;
  int n, bad;

  initial begin
    ifc.ascii_in = 8'h00;
    ifc.ascii_valid = 1'b0;
    repeat (3) @(negedge clk);
    // reset state
    chk("rst_ps2_clk",  {31'd0, ps2_clk}, 32'd1);
    chk("rst_ps2_data", {31'd0, ps2_data}, 32'd1);
    chk("rst_ready",    {31'd0, ifc.ascii_ready}, 32'd1);
    chk("rst_busy",     {31'd0, busy}, 32'd0);
    chk("rst_unmapped", {31'd0, unmapped}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 'A': bit-level waveform of first frame, latency, byte sequence
    rx_q.delete();
    send(8'h41);
    chk("A_busy0",  {31'd0, busy}, 32'd1);
    chk("A_ready0", {31'd0, ifc.ascii_ready}, 32'd0);
    for (int i = 0; i <= 88; i++) begin
      clk_s[i] = ps2_clk;
      dat_s[i] = ps2_data;
      @(negedge clk);
    end
    chk("A_c0_start", {30'd0, clk_s[0], dat_s[0]}, 32'b10);
    chk("A_c4_low",   {30'd0, clk_s[4], dat_s[4]}, 32'b00);
    chk("A_c3_high",  {31'd0, clk_s[3]}, 32'd1);
    chk("A_bit1",     {30'd0, clk_s[8], dat_s[8]}, 32'b10);
    chk("A_bit3",     {30'd0, clk_s[28], dat_s[28]}, 32'b01);
    chk("A_parity",   {30'd0, clk_s[72], dat_s[72]}, 32'b10);
    chk("A_stop",     {30'd0, clk_s[84], dat_s[84]}, 32'b01);
    chk("A_gap",      {30'd0, clk_s[88], dat_s[88]}, 32'b11);
    wait_idle(n);
    chk("A_len",   32'(n + 89), 32'd312);
    chk("A_bytes", rx_pack(), 32'h001CF01C);
    chk("A_busy_end", {31'd0, busy}, 32'd0);

    // CR then '0' with valid held
    rx_q.delete();
    ifc.ascii_in = 8'h0D;
    ifc.ascii_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifc.ascii_in = 8'h30;
    n = 0;
    while (!ifc.ascii_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_gap", 32'(n), 32'd312);
    @(negedge clk);
    chk("b2b_accept", {31'd0, ifc.ascii_ready}, 32'd0);
    ifc.ascii_valid = 1'b0;
    wait_idle(n);
    chk("b2b_len", 32'(n), 32'd312);
    chk("b2b_cnt", 32'(rx_q.size()), 32'd6);
    if (rx_q.size() == 6)
      chk("b2b_bytes", {rx_q[0], rx_q[1], rx_q[2], rx_q[3]}, 32'h5AF05A45);
    if (rx_q.size() == 6)
      chk("b2b_tail", {16'd0, rx_q[4], rx_q[5]}, 32'h0000F045);

    // '*' and other unmapped codes
    rx_q.delete();
    foreach (um_a[k]) begin
      send(um_a[k]);
      chk($sformatf("um_%02h_pulse", um_a[k]), {29'd0, unmapped, ifc.ascii_ready, busy}, 32'b110);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (unmapped || !ps2_clk || !ps2_data || !ifc.ascii_ready) bad++;
      end
      chk($sformatf("um_%02h_quiet", um_a[k]), 32'(bad), 32'd0);
    end
    chk("um_no_bytes", 32'(rx_q.size()), 32'd0);

    // lowercase 'a'
    rx_q.delete();
    send(8'h61);
`ifdef PS2_TX_CASEFOLD_EN
    chk("a_unmapped", {31'd0, unmapped}, 32'd0);
    wait_idle(n);
    chk("a_bytes", rx_pack(), 32'h001CF01C);
`else
    chk("a_unmapped", {31'd0, unmapped}, 32'd1);
    repeat (20) @(negedge clk);
    chk("a_bytes", 32'(rx_q.size()), 32'd0);
`endif

    // reset at cycle 40 of the first frame of 'Z'
    rx_q.delete();
    send(8'h5A);
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid_lines", {28'd0, ps2_clk, ps2_data, busy, ifc.ascii_ready}, 32'b1101);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_no_bytes", 32'(rx_q.size()), 32'd0);
    send(8'h5A);
    wait_idle(n);
    chk("Z_len", 32'(n), 32'd312);
    chk("Z_bytes", rx_pack(), 32'h001AF01A);

    // every mapped character through the host model
    foreach (mp_a[k]) begin
      rx_q.delete();
      send(mp_a[k]);
      wait_idle(n);
      chk($sformatf("map_%02h", mp_a[k]), rx_pack(), {8'h00, mp_c[k], 8'hF0, mp_c[k]});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
